// File: rtl/uart_rx_decoder.sv
// 8N1 UART receiver on a 16x sample tick. Each received ASCII character is decoded to a
// 3-bit alignment symbol, and valid symbols are queued in a first-word-fall-through FIFO.
module uart_rx_decoder #(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned STOP_TICK     = 16,
  parameter int unsigned ADDR_SIZE_EXP = 4,
  parameter int unsigned CODE_BITS     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx,
  input  logic                 rd_from_fifo,
  input  logic                 clr_err,
  output logic [CODE_BITS-1:0] rd_data_out,
  output logic                 empty,
  output logic                 full,
  output logic                 frame_err,
  output logic                 char_err,
  output logic                 overflow
);

  localparam int unsigned TICK_W = ($clog2(STOP_TICK) > 4) ? $clog2(STOP_TICK) : 4;
  localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned PTR_W  = ADDR_SIZE_EXP + 1;
  localparam int unsigned DEPTH  = 1 << ADDR_SIZE_EXP;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                 r_state;
  logic                   r_rx_meta;
  logic                   r_rx_sync;
  logic [TICK_W-1:0]      r_tick_cnt;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shreg;
  logic                   r_wr_en;
  logic [CODE_BITS-1:0]   r_wr_code;
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [CODE_BITS-1:0]   r_mem [DEPTH];

  logic [7:0]             w_byte;
  logic [CODE_BITS-1:0]   w_code;
  logic                   w_code_ok;
  logic                   w_rd_do;
  logic                   w_wr_do;
  logic                   w_drop;
  logic [PTR_W-1:0]       w_wptr_nxt;
  logic [PTR_W-1:0]       w_rptr_nxt;

  // Two-flop synchroniser; presets to the idle line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Character to symbol table; anything else is a character error
  assign w_byte = 8'(r_shreg);
  always_comb begin
    w_code    = '0;
    w_code_ok = 1'b1;
    case (w_byte)
      8'h41, 8'h61: w_code = CODE_BITS'(0);
      8'h43, 8'h63: w_code = CODE_BITS'(1);
      8'h47, 8'h67: w_code = CODE_BITS'(2);
      8'h54, 8'h74: w_code = CODE_BITS'(3);
      8'h2D:        w_code = CODE_BITS'(4);
      default:      w_code_ok = 1'b0;
    endcase
  end

  // Receive FSM; decode result is registered on the valid stop sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_code  <= '0;
      frame_err  <= 1'b0;
      char_err   <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      frame_err <= 1'b0;
      char_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tick_cnt <= '0;
          if (!r_rx_sync) r_state <= S_START;
        end
        S_START: begin
          if (sample_tick) begin
            if (r_tick_cnt == TICK_W'(7)) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_state    <= r_rx_sync ? S_IDLE : S_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end
        S_DATA: begin
          if (sample_tick) begin
            if (r_tick_cnt == TICK_W'(15)) begin
              r_tick_cnt <= '0;
              r_shreg    <= {r_rx_sync, r_shreg[DATA_BITS-1:1]};
              if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) r_state <= S_STOP;
              else r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end
        S_STOP: begin
          if (sample_tick) begin
            if (r_tick_cnt == TICK_W'(STOP_TICK - 1)) begin
              r_tick_cnt <= '0;
              r_state    <= S_IDLE;
              if (r_rx_sync) begin
                r_wr_en   <= w_code_ok;
                r_wr_code <= w_code;
                char_err  <= ~w_code_ok;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A write to a full FIFO only proceeds when a pop frees a slot in the same cycle
  assign w_rd_do    = rd_from_fifo & ~empty;
  assign w_wr_do    = r_wr_en & (~full | w_rd_do);
  assign w_drop     = r_wr_en & full & ~w_rd_do;
  assign w_wptr_nxt = r_wptr + PTR_W'(w_wr_do);
  assign w_rptr_nxt = r_rptr + PTR_W'(w_rd_do);

  always_ff @(posedge clk) begin
    if (w_wr_do) r_mem[r_wptr[ADDR_SIZE_EXP-1:0]] <= r_wr_code;
  end

  // Flags and head are registered from next-state pointers; bypass when the head is being written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      rd_data_out <= '0;
      overflow    <= 1'b0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
      empty  <= (w_wptr_nxt == w_rptr_nxt);
      full   <= (w_wptr_nxt[PTR_W-1] != w_rptr_nxt[PTR_W-1]) &&
                (w_wptr_nxt[PTR_W-2:0] == w_rptr_nxt[PTR_W-2:0]);
      if (w_wr_do && (r_wptr == w_rptr_nxt)) rd_data_out <= r_wr_code;
      else rd_data_out <= r_mem[w_rptr_nxt[ADDR_SIZE_EXP-1:0]];
      if (w_drop) overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_decoder.md
Name: uart_rx_decoder

Overview:
Receive-side counterpart of the channel transmit path. Deserialises one 8N1 UART line using the shared 16x-oversampling baud tick and decodes each received ASCII character into the 3-bit symbol code used by the alignment core. Valid symbols are buffered in an internal FIFO that the core pops with a read strobe. One instance is used per sequence channel (A and B).

Parameters:
DATA_BITS, 8, data bits per frame, LSB first.
STOP_TICK, 16, sample ticks in the stop bit (16 = 1 stop bit).
ADDR_SIZE_EXP, 4, FIFO depth is 2**ADDR_SIZE_EXP entries.
CODE_BITS, 3, width of a decoded symbol.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
sample_tick  in  1  one-cycle pulse at 16x the baud rate, from baud_rate_generator.
rx  in  1  serial input; idles high; asynchronous to clk.
rd_from_fifo  in  1  pop strobe; ignored when empty.
clr_err  in  1  clears the sticky overflow flag.
rd_data_out  out  CODE_BITS  FIFO head, first-word-fall-through.
empty  out  1  FIFO empty.
full  out  1  FIFO full.
frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
char_err  out  1  one-cycle pulse when a received byte is not in the symbol table.
overflow  out  1  sticky; set when a valid symbol is dropped because the FIFO is full.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM returns to IDLE; all counters and pointers clear.
  - Outputs: rd_data_out=0, empty=1, full=0, frame_err=0, char_err=0, overflow=0.
  - Synchroniser flops preset to 1.
  - Reset mid-frame abandons the partial byte; nothing is written to the FIFO.
- rx passes through a 2-flop synchroniser. All FSM decisions use the synchronised value.
- The FSM has four states; counters advance only on cycles where sample_tick=1.
  - IDLE: go to START when synchronised rx=0. The tick counter clears.
  - START: after 7 ticks (mid start bit), sample rx.
    - rx=0: clear counters, go to DATA.
    - rx=1: glitch; return to IDLE with no error.
  - DATA: every 16th tick, shift rx into the MSB of the shift register (LSB-first reception). After DATA_BITS samples, go to STOP.
  - STOP: after STOP_TICK ticks, sample rx.
    - rx=1: the byte is valid.
    - rx=0: pulse frame_err for 1 cycle and discard the byte.
    - In both cases go to IDLE.
- Decode happens in the cycle of the valid stop sample and is registered. Upper and lower case are both accepted:
  - 'A'/'a' (0x41/0x61) -> 000
  - 'C'/'c' (0x43/0x63) -> 001
  - 'G'/'g' (0x47/0x67) -> 010
  - 'T'/'t' (0x54/0x74) -> 011
  - '-' (0x2D) -> 100
  - Any other byte: pulse char_err for 1 cycle; no write.
- FIFO write occurs one clk cycle after the valid stop sample. A written symbol is visible on rd_data_out, with empty=0, on the following edge.
- Read: rd_from_fifo=1 while empty=0 advances the read pointer. rd_data_out shows the next entry on the next cycle.
- Pointers are ADDR_SIZE_EXP+1 bits wide so full and empty are unambiguous.
  - full: MSBs differ and the lower bits are equal.
  - empty: the pointers are equal.
  - Pointers wrap naturally modulo 2**(ADDR_SIZE_EXP+1).
- Write while full:
  - With no read in the same cycle: the symbol is dropped and overflow is set.
  - With a read in the same cycle: both proceed, full stays 1, overflow is not set.
- Read and write in the same cycle while empty: the write occurs, the read is ignored, and empty=0 on the next cycle.
- clr_err=1 clears overflow. If a drop occurs in the same cycle, set wins.
- Back-to-back frames: after STOP the FSM enters IDLE and accepts a new start bit immediately. No idle ticks are required beyond the stop bit.

Test Plan:
- Send 0x41 then 0x74 at the 16x tick rate -> rd_data_out=000, empty=0; pop -> rd_data_out=011; pop -> empty=1. No error pulses.
- Send 0x5A ('Z') -> char_err pulses once; empty remains 1.
- Send 0x43 with the stop bit held low -> frame_err pulses once; no FIFO write.
- Pull rx low for 3 ticks only -> FSM returns to IDLE; no write, no error.
- Send 17 valid 'G' with ADDR_SIZE_EXP=4 and no reads:
  - full=1 after the 16th symbol; the 17th sets overflow=1.
  - clr_err clears overflow.
  - 16 pops return 010 each and then empty=1.
- Assert rst low mid-DATA, release, then send '-' -> only code 100 is present in the FIFO; the earlier partial byte is lost.
